// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards MEM/WB results into SrcA/SrcB,
// and inserts a single bubble on load-use hazards. Optional counters under ALU_STAGE_PERF_EN.
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
    input  logic                      in_uses_rs2,
    input  logic                      in_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  in_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic                      in_reg_write,
    input  logic                      in_mem_read,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
`ifdef ALU_STAGE_PERF_EN
    output logic [31:0]               bubble_count,
    output logic [31:0]               flush_count,
`endif
    input  logic                      fwd_mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
    input  logic                      fwd_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_wb_data
);

    logic [DATA_WIDTH-1:0]     rs1_data, rs2_data, imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr, rs2_addr;
    logic                      alu_src;
    logic                      advance, hazard;
    logic [DATA_WIDTH-1:0]     rs1_fwd, rs2_fwd;

    assign advance  = ~out_valid | out_ready;
    assign hazard   = out_valid & out_mem_read & (out_rd_addr != '0) & in_valid &
                      ((in_rs1_addr == out_rd_addr) | (in_uses_rs2 & (in_rs2_addr == out_rd_addr)));
    assign in_ready = advance & ~hazard & ~flush;

    // MEM is younger than WB, so it wins when both target the same register.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0]     rf,
        input logic                      mem_v,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic [DATA_WIDTH-1:0]     mem_d,
        input logic                      wb_v,
        input logic [REG_ADDR_WIDTH-1:0] wb_rd,
        input logic [DATA_WIDTH-1:0]     wb_d
    );
        if (addr == '0)                     return rf;
        else if (mem_v && (mem_rd == addr)) return mem_d;
        else if (wb_v && (wb_rd == addr))   return wb_d;
        else                                return rf;
    endfunction

    always_comb begin
        rs1_fwd = fwd_sel(rs1_addr, rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs2_fwd = fwd_sel(rs2_addr, rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end

    assign SrcA           = rs1_fwd;
    assign SrcB           = alu_src ? imm : rs2_fwd;
    assign out_store_data = rs2_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            imm           <= '0;
            rs1_addr      <= '0;
            rs2_addr      <= '0;
            alu_src       <= 1'b0;
            Operation     <= '0;
            out_rd_addr   <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance && hazard) begin
            // Bubble must not write back or look like a load to later stages.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (advance) begin
            out_valid     <= in_valid;
            rs1_data      <= in_rs1_data;
            rs2_data      <= in_rs2_data;
            imm           <= in_imm;
            rs1_addr      <= in_rs1_addr;
            rs2_addr      <= in_rs2_addr;
            alu_src       <= in_alu_src;
            Operation     <= in_alu_op;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write;
            out_mem_read  <= in_mem_read;
        end
    end

`ifdef ALU_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (!flush && advance && hazard && (bubble_count != 32'hFFFF_FFFF))
                bubble_count <= bubble_count + 32'd1;
            if (flush && out_valid && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a slot-level reference model checked every cycle,
// plus hand-computed literal expectations at each scenario.
module tb_alu_operand_stage;
    localparam int DW = 32, OW = 4, AW = 5;

    logic clk = 0, rst_n = 0;
    logic in_valid, in_ready, in_uses_rs2, in_alu_src, in_reg_write, in_mem_read;
    logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [OW-1:0] in_alu_op;
    logic flush, out_ready, out_valid, out_reg_write, out_mem_read;
    logic [DW-1:0] SrcA, SrcB, out_store_data;
    logic [OW-1:0] Operation;
    logic [AW-1:0] out_rd_addr;
    logic fwd_mem_valid, fwd_wb_valid;
    logic [AW-1:0] fwd_mem_rd, fwd_wb_rd;
    logic [DW-1:0] fwd_mem_data, fwd_wb_data;
`ifdef ALU_STAGE_PERF_EN
    logic [31:0] bubble_count, flush_count;
`endif

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_uses_rs2(in_uses_rs2),
        .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
`ifdef ALU_STAGE_PERF_EN
        .bubble_count(bubble_count), .flush_count(flush_count),
`endif
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data)
    );

    // Reference: the one instruction slot in flight, as an abstract record.
    typedef struct {
        bit valid;
        bit [DW-1:0] a, b, imm;
        bit [AW-1:0] ra, rb, rd;
        bit use_imm, wr, ld;
        bit [OW-1:0] op;
    } slot_t;
    slot_t s;
    int bubbles = 0, flushes = 0;

    function automatic bit model_hazard();
        if (!(s.valid && s.ld && s.rd != 0 && in_valid)) return 0;
        return (in_rs1_addr == s.rd) || (in_uses_rs2 && in_rs2_addr == s.rd);
    endfunction

    function automatic bit [DW-1:0] resolve(bit [AW-1:0] r, bit [DW-1:0] rf);
        if (r == 0) return rf;
        if (fwd_mem_valid && fwd_mem_rd == r) return fwd_mem_data;
        if (fwd_wb_valid && fwd_wb_rd == r) return fwd_wb_data;
        return rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s = '{default: 0};
        end else begin
            bit free, hz;
            free = !s.valid || out_ready;
            hz = model_hazard();
            if (flush) begin
                if (s.valid) flushes++;
                s.valid = 0;
            end else if (free && hz) begin
                bubbles++;
                s.valid = 0; s.wr = 0; s.ld = 0;
            end else if (free) begin
                s = '{valid: in_valid, a: in_rs1_data, b: in_rs2_data, imm: in_imm,
                      ra: in_rs1_addr, rb: in_rs2_addr, rd: in_rd_addr, use_imm: in_alu_src,
                      wr: in_reg_write, ld: in_mem_read, op: in_alu_op};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            bit [DW-1:0] ea, eb;
            chk("m_in_ready", {31'd0, in_ready},
                {31'd0, (!s.valid || out_ready) && !model_hazard() && !flush});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, s.valid});
            chk("m_reg_write", {31'd0, out_reg_write}, {31'd0, s.wr});
            chk("m_mem_read", {31'd0, out_mem_read}, {31'd0, s.ld});
            if (s.valid) begin
                ea = resolve(s.ra, s.a);
                eb = resolve(s.rb, s.b);
                chk("m_srca", SrcA, ea);
                chk("m_srcb", SrcB, s.use_imm ? s.imm : eb);
                chk("m_store", out_store_data, eb);
                chk("m_op", {28'd0, Operation}, {28'd0, s.op});
                chk("m_rd", {27'd0, out_rd_addr}, {27'd0, s.rd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [AW-1:0] ra, rb, rd, input logic [DW-1:0] a, b, imm,
                             input logic [OW-1:0] op, input logic urs2, src, wr, ld);
        in_valid = 1; in_rs1_addr = ra; in_rs2_addr = rb; in_rd_addr = rd;
        in_rs1_data = a; in_rs2_data = b; in_imm = imm; in_alu_op = op;
        in_uses_rs2 = urs2; in_alu_src = src; in_reg_write = wr; in_mem_read = ld;
    endtask

    initial begin
        in_valid = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_uses_rs2 = 0; in_alu_src = 0;
        in_alu_op = 0; in_rd_addr = 0; in_reg_write = 0; in_mem_read = 0;
        flush = 0; out_ready = 1;
        fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
        tick(); tick();
        rst_n = 1;
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_op", {28'd0, Operation}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back ADDs
        set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0101, 1, 0, 1, 0);
        tick();
        chk("add1_valid", {31'd0, out_valid}, 32'd1);
        chk("add1_srca", SrcA, 32'd5);
        chk("add1_srcb", SrcB, 32'd7);
        chk("add1_op", {28'd0, Operation}, 32'h5);
        chk("add1_in_ready", {31'd0, in_ready}, 32'd1);
        in_rs1_data = 32'd9;
        tick();
        chk("add2_srca", SrcA, 32'd9);
        chk("add2_valid", {31'd0, out_valid}, 32'd1);

        // MEM/WB forwarding priority, plus immediate SrcB
        set_instr(5'd3, 5'd2, 5'd8, 32'h11, 32'h22, 32'h1234, 4'b0000, 0, 1, 1, 0);
        tick();
        in_valid = 0;
        fwd_mem_valid = 1; fwd_mem_rd = 3; fwd_mem_data = 32'hAA;
        fwd_wb_valid = 1; fwd_wb_rd = 3; fwd_wb_data = 32'hBB;
        #1;
        chk("fwd_mem_srca", SrcA, 32'hAA);
        chk("fwd_imm_srcb", SrcB, 32'h1234);
        chk("fwd_store", out_store_data, 32'h22);
        fwd_mem_valid = 0;
        #1;
        chk("fwd_wb_srca", SrcA, 32'hBB);
        fwd_wb_valid = 0;
        tick();

        // x0 is never forwarded
        set_instr(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 4'b0101, 1, 0, 1, 0);
        fwd_mem_valid = 1; fwd_mem_rd = 0; fwd_mem_data = 32'h55;
        tick();
        in_valid = 0;
        chk("x0_srca", SrcA, 32'd0);
        chk("x0_store", out_store_data, 32'd0);
        fwd_mem_valid = 0;
        tick();

        // Load-use hazard: LW x4 then ADD reading x4
        set_instr(5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 4'b0000, 0, 1, 1, 1);
        tick();
        set_instr(5'd1, 5'd4, 5'd6, 32'h100, 32'hDEAD, 32'd0, 4'b0101, 1, 0, 1, 0);
        #1;
        chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("lu_bubble_wr", {31'd0, out_reg_write}, 32'd0);
        chk("lu_accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
        fwd_wb_valid = 1; fwd_wb_rd = 4; fwd_wb_data = 32'h77;
        #1;
        chk("lu_add_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_add_srcb", SrcB, 32'h77);
        chk("lu_add_srca", SrcA, 32'h100);
`ifdef ALU_STAGE_PERF_EN
        chk("bubble_count", bubble_count, 32'd1);
`endif

        // Stall holds, then flush while stalled
        out_ready = 0;
        set_instr(5'd9, 5'd10, 5'd11, 32'h3, 32'h4, 32'd0, 4'b1010, 1, 0, 1, 0);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("stall_hold_op", {28'd0, Operation}, 32'h5);
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        fwd_wb_valid = 0;
        flush = 1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_not_captured", {28'd0, Operation}, 32'h5);
`ifdef ALU_STAGE_PERF_EN
        chk("flush_count", flush_count, 32'd1);
`endif
        tick();

        // Asynchronous reset mid-operation
        set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0101, 1, 0, 1, 0);
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_op", {28'd0, Operation}, 32'd0);
`ifdef ALU_STAGE_PERF_EN
        chk("rst_bubble_count", bubble_count, 32'd0);
`endif
        tick();
        rst_n = 1;
        tick();
        chk("model_bubbles", bubbles, 32'd1);
        chk("model_flushes", flushes, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
